binary_decoder_pipe: RTL

//  Multi-lane, pipelined binary-to-unary decoder with valid/ready flow control.

---
 rtl/binary_decoder_pkg.sv | 30 +++
 rtl/binary_decoder_pipe_stage.sv | 33 +++
 rtl/binary_decoder_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/binary_decoder_pkg.sv
// Shared decode helper and lane-record sizing for binary_decoder_pipe.
// Lane records are {err, vector}; the widest supported lane sets the helper widths.
package binary_decoder_pkg;

  localparam int unsigned MAX_BIN_WIDTH   = 8;
  localparam int unsigned MAX_UNARY_WIDTH = 1 << MAX_BIN_WIDTH;
  localparam int unsigned LANE_W          = MAX_UNARY_WIDTH + 1;

  // One extra bit so a full-range UNARY_WIDTH limit fits in the compare.
  typedef logic [MAX_BIN_WIDTH:0] code_t;
  typedef logic [LANE_W-1:0]      lane_t;

  // Returns {err, vector}; callers keep only the low UNARY_WIDTH vector bits.
  function automatic lane_t decode_lane(input code_t bin, input logic en, input logic thermo,
                                        input code_t limit);
    lane_t r;
    r = '0;
    if (en) begin
      if (bin >= limit) begin
        r[LANE_W-1] = 1'b1;
      end else begin
        for (int i = 0; i < int'(MAX_UNARY_WIDTH); i++) begin
          r[i] = thermo ? (i <= int'(bin)) : (i == int'(bin));
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/binary_decoder_pipe_stage.sv
// Single valid/ready register slice; accepts when empty or when its content leaves this cycle.
module binary_decoder_pipe_stage #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Data only moves on a load so a stalled slice holds its beat unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/binary_decoder_pipe.sv
// Multi-lane pipelined binary-to-unary decoder with valid/ready flow control
// and an optional sticky OR mask of delivered beats.
module binary_decoder_pipe
  import binary_decoder_pkg::*;
#(
  parameter int unsigned BIN_WIDTH   = 8,
  parameter int unsigned UNARY_WIDTH = 1 << BIN_WIDTH,
  parameter int unsigned LANES       = 1,
  parameter int unsigned STAGES      = 1,
  parameter int unsigned THERMO      = 0,
  parameter int unsigned ACCUMULATE  = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [LANES-1:0]               i_en,
  input  logic [LANES*BIN_WIDTH-1:0]     i_bin,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [LANES*UNARY_WIDTH-1:0]   o_unary,
  output logic [LANES-1:0]               o_err,
  input  logic                           i_clear,
  output logic [LANES*UNARY_WIDTH-1:0]   o_mask
);

  localparam int unsigned LaneW = UNARY_WIDTH + 1;
  localparam int unsigned DataW = LANES * LaneW;
  localparam code_t       Limit = code_t'(UNARY_WIDTH);

  logic [DataW-1:0] dec;
  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [DataW-1:0] dat [STAGES+1];
  logic             handshake;

  always_comb begin
    code_t bin;
    lane_t r;
    dec = '0;
    bin = '0;
    r   = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      bin = '0;
      bin[BIN_WIDTH-1:0] = i_bin[k*BIN_WIDTH +: BIN_WIDTH];
      r = decode_lane(bin, i_en[k], THERMO != 0, Limit);
      dec[k*LaneW +: LaneW] = {r[LANE_W-1], r[UNARY_WIDTH-1:0]};
    end
  end

  assign vld[0]      = i_valid;
  assign dat[0]      = dec;
  assign o_ready     = rdy[0];
  assign rdy[STAGES] = i_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    binary_decoder_pipe_stage #(
      .Width(DataW)
    ) u_stage (
      .clk      (i_clk),
      .rst      (i_rst),
      .in_valid (vld[s]),
      .in_ready (rdy[s]),
      .in_data  (dat[s]),
      .out_valid(vld[s+1]),
      .out_ready(rdy[s+1]),
      .out_data (dat[s+1])
    );
  end

  assign o_valid   = vld[STAGES];
  assign handshake = o_valid && i_ready;

  always_comb begin
    o_unary = '0;
    o_err   = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      o_unary[k*UNARY_WIDTH +: UNARY_WIDTH] = dat[STAGES][k*LaneW +: UNARY_WIDTH];
      o_err[k] = dat[STAGES][k*LaneW + UNARY_WIDTH];
    end
  end

  if (ACCUMULATE != 0) begin : g_acc
    logic [LANES*UNARY_WIDTH-1:0] mask_q;
    // Clear takes effect before the same-cycle beat is ORed in.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        mask_q <= '0;
      end else if (i_clear) begin
        mask_q <= handshake ? o_unary : '0;
      end else if (handshake) begin
        mask_q <= mask_q | o_unary;
      end
    end
    assign o_mask = mask_q;
  end else begin : g_no_acc
    assign o_mask = '0;
  end

endmodule
